// File: rtl/repairval_sb_tx_serializer_if.sv
// Wrapper-to-serializer bundle: parallel message/valid in, framed serial lane and status out.
// The master side is the REPAIRVAL wrapper; the slave side is the serializer.
interface repairval_sb_tx_serializer_if #(
    parameter int MSG_W = 4
);
    logic [MSG_W-1:0] i_TX_SbMessage;
    logic             i_ValidOutData;
    logic             o_sb_data;
    logic             o_sb_frame;
    logic             o_busy;
    logic             o_falling_edge_busy;
    logic             o_overflow;
    logic [1:0]       o_queue_level;

    modport master (
        output i_TX_SbMessage, i_ValidOutData,
        input  o_sb_data, o_sb_frame, o_busy, o_falling_edge_busy, o_overflow, o_queue_level
    );

    modport slave (
        input  i_TX_SbMessage, i_ValidOutData,
        output o_sb_data, o_sb_frame, o_busy, o_falling_edge_busy, o_overflow, o_queue_level
    );
endinterface

// File: rtl/repairval_sb_tx_serializer.sv
// Sideband TX serializer: captures new REPAIRVAL codes into a 2-deep queue and sends start/data/parity/stop frames.
// Latency: capture at edge N, pop at N+1, start bit on the lane after N+2; lane outputs are registered.
// Backpressure: none upstream; a capture into a full queue without a same-cycle pop is dropped and flagged sticky.
module repairval_sb_tx_serializer #(
    parameter int MSG_W      = 4,
    parameter int BIT_CYCLES = 1,
    parameter int GAP_CYCLES = 2
) (
    input  logic                        dut1_CLK,
    input  logic                        dut1_rst_n,
    repairval_sb_tx_serializer_if.slave sb
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;
    localparam int         BIW      = (MSG_W > 1) ? $clog2(MSG_W) : 1;

    logic [2:0]       state_q, state_d;
    logic [MSG_W-1:0] shreg_q, shreg_d;
    logic [BIW-1:0]   bit_idx_q, bit_idx_d;
    logic [3:0]       dwell_q, dwell_d;
    logic [3:0]       gap_q, gap_d;
    logic [MSG_W-1:0] mem_q [2];
    logic [MSG_W-1:0] mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             prev_valid_q, prev_valid_d;
    logic [MSG_W-1:0] last_q, last_d;
    logic             sb_data_q, sb_data_d;
    logic             sb_frame_q, sb_frame_d;
    logic             busy_q, busy_d;
    logic             feb_q, feb_d;

    logic capture, push, pop, bit_done, gap_done, in_frame;

    always_comb begin
        // A held valid with an unchanged code is one message, not a stream of them.
        capture = sb.i_ValidOutData && (sb.i_TX_SbMessage != '0) &&
                  (!prev_valid_q || (sb.i_TX_SbMessage != last_q));
        prev_valid_d = sb.i_ValidOutData;
        last_d       = capture ? sb.i_TX_SbMessage : last_q;

        bit_done  = (dwell_q == 4'(BIT_CYCLES - 1));
        gap_done  = (gap_q == 4'(GAP_CYCLES - 1));
        in_frame  = (state_q == S_START) || (state_q == S_DATA) ||
                    (state_q == S_PARITY) || (state_q == S_STOP);

        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        gap_d     = gap_q;
        pop       = 1'b0;
        dwell_d   = in_frame ? (bit_done ? 4'd0 : dwell_q + 4'd1) : 4'd0;

        case (state_q)
            S_IDLE: begin
                if (level_q != 2'd0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == BIW'(MSG_W - 1)) state_d = S_PARITY;
                    else                              bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_done) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_done) begin
                    gap_d   = 4'd0;
                    state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                // The last gap cycle already pops, so exactly GAP_CYCLES idle cycles separate frames.
                if (gap_done) begin
                    if (level_q != 2'd0) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) shreg_d = mem_q[rd_ptr_q];

        push = capture && ((level_q != 2'd2) || pop);
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = sb.i_TX_SbMessage;
        wr_ptr_d   = wr_ptr_q ^ push;
        rd_ptr_d   = rd_ptr_q ^ pop;
        level_d    = level_q + {1'b0, push} - {1'b0, pop};
        overflow_d = overflow_q | (capture & ~push);

        sb_frame_d = in_frame;
        case (state_q)
            S_START:  sb_data_d = 1'b1;
            S_DATA:   sb_data_d = shreg_q[bit_idx_q];
            S_PARITY: sb_data_d = ^shreg_q;
            default:  sb_data_d = 1'b0;
        endcase
        busy_d = in_frame;
        feb_d  = busy_q & ~busy_d;
    end

    always_ff @(posedge dut1_CLK or negedge dut1_rst_n) begin
        if (!dut1_rst_n) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bit_idx_q    <= '0;
            dwell_q      <= '0;
            gap_q        <= '0;
            mem_q        <= '{default: '0};
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            level_q      <= 2'd0;
            overflow_q   <= 1'b0;
            prev_valid_q <= 1'b0;
            last_q       <= '0;
            sb_data_q    <= 1'b0;
            sb_frame_q   <= 1'b0;
            busy_q       <= 1'b0;
            feb_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_idx_q    <= bit_idx_d;
            dwell_q      <= dwell_d;
            gap_q        <= gap_d;
            mem_q        <= mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            prev_valid_q <= prev_valid_d;
            last_q       <= last_d;
            sb_data_q    <= sb_data_d;
            sb_frame_q   <= sb_frame_d;
            busy_q       <= busy_d;
            feb_q        <= feb_d;
        end
    end

    assign sb.o_sb_data           = sb_data_q;
    assign sb.o_sb_frame          = sb_frame_q;
    assign sb.o_busy              = busy_q;
    assign sb.o_falling_edge_busy = feb_q;
    assign sb.o_overflow          = overflow_q;
    assign sb.o_queue_level       = level_q;

endmodule
